// File: rtl/dsp_mac_sequencer.sv
// Operand/result sequencer for one DSP48A1 slice used as an unsigned dot-product MAC.
// Optional result clipping is enabled by defining MACSEQ_SAT_EN.
module dsp_mac_sequencer #(
  parameter int WIDTH_AB = 18,
  parameter int WIDTH_P  = 48,
  parameter int WIDTH_R  = 40,
  parameter int CNT_W    = 10,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                S_VALID,
  output logic                S_READY,
  input  logic [WIDTH_AB-1:0] S_A,
  input  logic [WIDTH_AB-1:0] S_B,
  input  logic                S_LAST,
  output logic [WIDTH_AB-1:0] DSP_A,
  output logic [WIDTH_AB-1:0] DSP_B,
  output logic [7:0]          DSP_OPMODE,
  input  logic [WIDTH_P-1:0]  DSP_P,
  output logic                R_VALID,
  input  logic                R_READY,
  output logic [WIDTH_R-1:0]  R_DATA,
  output logic [CNT_W-1:0]    R_COUNT,
  output logic                R_SAT
);

  localparam logic [7:0] OPM_START = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  localparam logic [7:0] OPM_CLR   = 8'h00;

  localparam int DRAIN_N = PIPE_LAT + OPM_DLY;
  localparam int DRAIN_W = $clog2(DRAIN_N + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t             state_r;
  logic [7:0]         opcode_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [DRAIN_W-1:0] drain_cnt_r;
  logic [7:0]         opm_pipe_r [OPM_DLY];
  logic               accept_s;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

`ifdef MACSEQ_SAT_EN
  function automatic logic p_overflow(input logic [WIDTH_P-1:0] p);
    return (p >> WIDTH_R) != {WIDTH_P{1'b0}};
  endfunction
`else
  logic unused_p_s;
  assign unused_p_s = ^(DSP_P >> WIDTH_R);
`endif

  assign accept_s = S_VALID & S_READY;

  // Sequencer FSM: operand capture, opcode choice, pipeline drain and result hand-off.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      S_READY     <= 1'b0;
      R_VALID     <= 1'b0;
      R_DATA      <= {WIDTH_R{1'b0}};
      R_COUNT     <= {CNT_W{1'b0}};
      R_SAT       <= 1'b0;
      DSP_A       <= {WIDTH_AB{1'b0}};
      DSP_B       <= {WIDTH_AB{1'b0}};
      opcode_r    <= OPM_CLR;
      beat_cnt_r  <= {CNT_W{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, RUN: begin
          if (accept_s) begin
            DSP_A <= S_A;
            DSP_B <= S_B;
            if (state_r == IDLE) begin
              opcode_r   <= OPM_START;
              beat_cnt_r <= CNT_W'(1);
            end else begin
              opcode_r   <= OPM_ACC;
              beat_cnt_r <= cnt_inc(beat_cnt_r);
            end
            if (S_LAST) begin
              state_r     <= DRAIN;
              S_READY     <= 1'b0;
              drain_cnt_r <= {DRAIN_W{1'b0}};
            end else begin
              state_r <= RUN;
              S_READY <= 1'b1;
            end
          end else begin
            // A bubble inside an open vector must keep P; an idle slice is held clear.
            opcode_r <= (state_r == RUN) ? OPM_HOLD : OPM_CLR;
            S_READY  <= 1'b1;
          end
        end
        DRAIN: begin
          opcode_r <= OPM_HOLD;
          S_READY  <= 1'b0;
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r <= RESULT;
            R_VALID <= 1'b1;
            R_COUNT <= beat_cnt_r;
`ifdef MACSEQ_SAT_EN
            if (p_overflow(DSP_P)) begin
              R_DATA <= {WIDTH_R{1'b1}};
              R_SAT  <= 1'b1;
            end else begin
              R_DATA <= DSP_P[WIDTH_R-1:0];
              R_SAT  <= 1'b0;
            end
`else
            R_DATA <= DSP_P[WIDTH_R-1:0];
            R_SAT  <= 1'b0;
`endif
          end else begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
          end
        end
        RESULT: begin
          opcode_r <= OPM_CLR;
          if (R_READY) begin
            state_r <= IDLE;
            R_VALID <= 1'b0;
            S_READY <= 1'b1;
          end else begin
            S_READY <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          opcode_r <= OPM_CLR;
          S_READY  <= 1'b0;
          R_VALID  <= 1'b0;
        end
      endcase
    end
  end

  // Opcode delay line so OPMODE reaches the slice together with its product.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < OPM_DLY; i++) begin
        opm_pipe_r[i] <= OPM_CLR;
      end
    end else begin
      opm_pipe_r[0] <= opcode_r;
      for (int i = 1; i < OPM_DLY; i++) begin
        opm_pipe_r[i] <= opm_pipe_r[i-1];
      end
    end
  end

  assign DSP_OPMODE = opm_pipe_r[OPM_DLY-1];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE regs).
module tb_dsp_mac_sequencer;

  localparam int WAB = 18;
  localparam int WP  = 48;
  localparam int WR  = 20;
  localparam int CW  = 10;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          S_VALID = 1'b0;
  logic          S_READY;
  logic [WAB-1:0] S_A = '0;
  logic [WAB-1:0] S_B = '0;
  logic          S_LAST = 1'b0;
  logic [WAB-1:0] DSP_A;
  logic [WAB-1:0] DSP_B;
  logic [7:0]    DSP_OPMODE;
  logic [WP-1:0] DSP_P;
  logic          R_VALID;
  logic          R_READY = 1'b1;
  logic [WR-1:0] R_DATA;
  logic [CW-1:0] R_COUNT;
  logic          R_SAT;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  dsp_mac_sequencer #(.WIDTH_AB(WAB), .WIDTH_P(WP), .WIDTH_R(WR), .CNT_W(CW),
                      .PIPE_LAT(3), .OPM_DLY(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_A(S_A), .S_B(S_B), .S_LAST(S_LAST), .DSP_A(DSP_A), .DSP_B(DSP_B),
    .DSP_OPMODE(DSP_OPMODE), .DSP_P(DSP_P), .R_VALID(R_VALID), .R_READY(R_READY),
    .R_DATA(R_DATA), .R_COUNT(R_COUNT), .R_SAT(R_SAT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Slice model: A1/B1 -> M -> P, OPMODE register aligned with M. Slice resets tied inactive.
  logic [WAB-1:0] a1_r = '0, b1_r = '0;
  logic [35:0]    m_r = '0;
  logic [7:0]     opm_r = '0;
  logic [WP-1:0]  p_r = '0;
  always @(posedge CLK) begin
    a1_r  <= DSP_A;
    b1_r  <= DSP_B;
    m_r   <= a1_r * b1_r;
    opm_r <= DSP_OPMODE;
    p_r   <= ((opm_r[1:0] == 2'b01) ? WP'(m_r) : '0) + ((opm_r[3:2] == 2'b10) ? p_r : '0);
  end
  assign DSP_P = p_r;

  task automatic send_beat(input logic [WAB-1:0] a, input logic [WAB-1:0] b, input logic last);
    int n = 0;
    S_VALID = 1'b1; S_A = a; S_B = b; S_LAST = last;
    while (!S_READY && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!S_READY) begin
      n_vec++; n_bad++;
      $display("FAIL send_beat: S_READY=%0b after %0d cycles, required 1", S_READY, n);
    end
    @(posedge CLK);
    @(negedge CLK);
    acc_cyc = cyc;
    S_VALID = 1'b0; S_LAST = 1'b0;
  endtask

  task automatic wait_result(output int rv_cyc, output bit ok);
    ok = 1'b0;
    rv_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (R_VALID) begin
        ok = 1'b1;
        rv_cyc = cyc;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++; if ({S_READY, R_VALID, R_SAT} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags: got %b required 000", {S_READY, R_VALID, R_SAT}); end
    n_vec++; if (R_DATA !== '0 || R_COUNT !== '0) begin n_bad++;
      $display("FAIL reset_result: data=%0d count=%0d required 0/0", R_DATA, R_COUNT); end
    n_vec++; if (DSP_A !== '0 || DSP_B !== '0 || DSP_OPMODE !== 8'h00) begin n_bad++;
      $display("FAIL reset_dsp: a=%0d b=%0d opm=%h required 0/0/00", DSP_A, DSP_B, DSP_OPMODE); end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_vec++; if (S_READY !== 1'b1 || DSP_OPMODE !== 8'h00) begin n_bad++;
      $display("FAIL idle_after_reset: s_ready=%0b opm=%h required 1/00", S_READY, DSP_OPMODE); end
  endtask

  task automatic test_back_to_back();
    int rv; bit ok;
    R_READY = 1'b1;
    send_beat(18'd2, 18'd3, 1'b0);
    n_vec++; if (DSP_A !== 18'd2 || DSP_B !== 18'd3) begin n_bad++;
      $display("FAIL b2b_operands: a=%0d b=%0d required 2/3", DSP_A, DSP_B); end
    send_beat(18'd4, 18'd5, 1'b0);
    n_vec++; if (DSP_OPMODE !== 8'h01) begin n_bad++;
      $display("FAIL b2b_opm_start: got %h required 01", DSP_OPMODE); end
    send_beat(18'd6, 18'd7, 1'b1);
    n_vec++; if (DSP_OPMODE !== 8'h09) begin n_bad++;
      $display("FAIL b2b_opm_acc: got %h required 09", DSP_OPMODE); end
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd68 || R_COUNT !== 10'd3 || R_SAT !== 1'b0) begin n_bad++;
      $display("FAIL b2b_result: valid=%0b data=%0d count=%0d sat=%0b required 1/68/3/0",
               ok, R_DATA, R_COUNT, R_SAT); end
    n_vec++; if (rv - acc_cyc !== 5) begin n_bad++;
      $display("FAIL b2b_latency: got %0d edges required 5", rv - acc_cyc); end
    @(negedge CLK);
    n_vec++; if (R_VALID !== 1'b0 || S_READY !== 1'b1) begin n_bad++;
      $display("FAIL b2b_handshake: r_valid=%0b s_ready=%0b required 0/1", R_VALID, S_READY); end
  endtask

  task automatic test_bubble();
    int rv; bit ok;
    send_beat(18'd2, 18'd3, 1'b0);
    @(negedge CLK);
    n_vec++; if (S_READY !== 1'b1) begin n_bad++;
      $display("FAIL bubble_ready1: got %0b required 1", S_READY); end
    @(negedge CLK);
    n_vec++; if (S_READY !== 1'b1 || DSP_OPMODE !== 8'h08) begin n_bad++;
      $display("FAIL bubble_hold: s_ready=%0b opm=%h required 1/08", S_READY, DSP_OPMODE); end
    send_beat(18'd4, 18'd5, 1'b0);
    send_beat(18'd6, 18'd7, 1'b1);
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd68 || R_COUNT !== 10'd3) begin n_bad++;
      $display("FAIL bubble_result: valid=%0b data=%0d count=%0d required 1/68/3", ok, R_DATA, R_COUNT); end
    @(negedge CLK);
  endtask

  task automatic test_single();
    int rv; bit ok;
    send_beat(18'd100, 18'd200, 1'b1);
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd20000 || R_COUNT !== 10'd1) begin n_bad++;
      $display("FAIL single_result: valid=%0b data=%0d count=%0d required 1/20000/1", ok, R_DATA, R_COUNT); end
    @(negedge CLK);
    send_beat(18'd3, 18'd4, 1'b1);
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd12 || R_COUNT !== 10'd1) begin n_bad++;
      $display("FAIL single_restart: valid=%0b data=%0d count=%0d required 1/12/1", ok, R_DATA, R_COUNT); end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int rv; bit ok;
    R_READY = 1'b0;
    send_beat(18'd2, 18'd3, 1'b1);
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd6) begin n_bad++;
      $display("FAIL bp_result: valid=%0b data=%0d required 1/6", ok, R_DATA); end
    S_VALID = 1'b1; S_A = 18'd1; S_B = 18'd1; S_LAST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_vec++; if (R_VALID !== 1'b1 || R_DATA !== 20'd6 || R_COUNT !== 10'd1 || S_READY !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_stall%0d: valid=%0b data=%0d count=%0d s_ready=%0b required 1/6/1/0",
                 i, R_VALID, R_DATA, R_COUNT, S_READY);
      end
    end
    R_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_vec++; if (R_VALID !== 1'b0 || S_READY !== 1'b1 || DSP_A !== 18'd2) begin n_bad++;
      $display("FAIL bp_release: valid=%0b s_ready=%0b dsp_a=%0d required 0/1/2", R_VALID, S_READY, DSP_A); end
    @(posedge CLK);
    @(negedge CLK);
    acc_cyc = cyc;
    S_VALID = 1'b0; S_LAST = 1'b0;
    n_vec++; if (DSP_A !== 18'd1 || S_READY !== 1'b0) begin n_bad++;
      $display("FAIL bp_accept: dsp_a=%0d s_ready=%0b required 1/0", DSP_A, S_READY); end
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd1 || R_COUNT !== 10'd1) begin n_bad++;
      $display("FAIL bp_second: valid=%0b data=%0d count=%0d required 1/1/1", ok, R_DATA, R_COUNT); end
    @(negedge CLK);
  endtask

  task automatic test_saturation();
    int rv; bit ok;
    logic [WR-1:0] exp_data;
    logic          exp_sat;
`ifdef MACSEQ_SAT_EN
    exp_data = 20'hFFFFF; exp_sat = 1'b1;
`else
    exp_data = 20'd1044482; exp_sat = 1'b0;
`endif
    send_beat(18'd1023, 18'd1023, 1'b0);
    send_beat(18'd1023, 18'd1023, 1'b1);
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== exp_data || R_SAT !== exp_sat || R_COUNT !== 10'd2) begin n_bad++;
      $display("FAIL sat_result: valid=%0b data=%0d sat=%0b count=%0d required 1/%0d/%0b/2",
               ok, R_DATA, R_SAT, R_COUNT, exp_data, exp_sat); end
    @(negedge CLK);
  endtask

  task automatic test_reset_midvector();
    int rv; bit ok; bit seen;
    send_beat(18'd7, 18'd7, 1'b0);
    send_beat(18'd8, 18'd8, 1'b0);
    RST_N = 1'b0;
    #1;
    n_vec++; if ({S_READY, R_VALID, R_SAT} !== 3'b000 || R_DATA !== '0 || R_COUNT !== '0) begin n_bad++;
      $display("FAIL midrst_result: flags=%b data=%0d count=%0d required 000/0/0",
               {S_READY, R_VALID, R_SAT}, R_DATA, R_COUNT); end
    n_vec++; if (DSP_A !== '0 || DSP_B !== '0 || DSP_OPMODE !== 8'h00) begin n_bad++;
      $display("FAIL midrst_dsp: a=%0d b=%0d opm=%h required 0/0/00", DSP_A, DSP_B, DSP_OPMODE); end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (R_VALID) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_bad++;
      $display("FAIL midrst_no_result: r_valid seen=%0b required 0", seen); end
    send_beat(18'd5, 18'd5, 1'b1);
    wait_result(rv, ok);
    n_vec++; if (!ok || R_DATA !== 20'd25 || R_COUNT !== 10'd1) begin n_bad++;
      $display("FAIL midrst_next: valid=%0b data=%0d count=%0d required 1/25/1", ok, R_DATA, R_COUNT); end
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_back_to_back();
    test_bubble();
    test_single();
    test_backpressure();
    test_saturation();
    test_reset_midvector();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
